// File: rtl/perf_counter_bank_if.sv
// Performance-counter bank bus: per-channel event pulses, done pulses and registered channel readout.
// PERF_MINMAX_EN adds the rd_min / rd_max readout signals.
interface perf_counter_bank_if #(
    parameter int unsigned NUM_CH  = 4,
    parameter int unsigned WIDTH   = 28,
    parameter int unsigned NMEAS_W = 16,
    parameter int unsigned SEL_W   = 2
);
    logic [NUM_CH-1:0]  cnt_start;
    logic [NUM_CH-1:0]  cnt_end;
    logic [NUM_CH-1:0]  cnt_clr;
    logic [NUM_CH-1:0]  done;
    logic [SEL_W-1:0]   rd_sel;
    logic [WIDTH-1:0]   rd_cnt;
    logic [WIDTH-1:0]   rd_last;
    logic [NMEAS_W-1:0] rd_nmeas;
    logic               rd_busy;
    logic               rd_sat;
`ifdef PERF_MINMAX_EN
    logic [WIDTH-1:0]   rd_min;
    logic [WIDTH-1:0]   rd_max;
`endif

    modport master (
        output cnt_start, cnt_end, cnt_clr, rd_sel,
        input  done, rd_cnt, rd_last, rd_nmeas, rd_busy, rd_sat
`ifdef PERF_MINMAX_EN
        , input rd_min, rd_max
`endif
    );

    modport slave (
        input  cnt_start, cnt_end, cnt_clr, rd_sel,
        output done, rd_cnt, rd_last, rd_nmeas, rd_busy, rd_sat
`ifdef PERF_MINMAX_EN
        , output rd_min, rd_max
`endif
    );
endinterface

// File: rtl/perf_counter_bank.sv
// Bank of NUM_CH independent start-to-end cycle counters with last latency, completion count and
// sticky saturation, read through a registered select port. PERF_MINMAX_EN adds per-channel min/max latency.
module perf_counter_bank #(
    parameter int unsigned NUM_CH  = 4,
    parameter int unsigned WIDTH   = 28,
    parameter int unsigned NMEAS_W = 16,
    parameter int unsigned SEL_W   = 2
) (
    input  logic               clk,
    input  logic               resetn,
    perf_counter_bank_if.slave bus
);
    typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

    localparam logic [WIDTH-1:0]   CNT_MAX   = '1;
    localparam logic [NMEAS_W-1:0] NMEAS_MAX = '1;

    state_t             r_state     [NUM_CH];
    state_t             w_state_nxt [NUM_CH];
    logic [WIDTH-1:0]   r_cnt       [NUM_CH];
    logic [WIDTH-1:0]   w_cnt_nxt   [NUM_CH];
    logic [WIDTH-1:0]   r_last      [NUM_CH];
    logic [WIDTH-1:0]   w_last_nxt  [NUM_CH];
    logic [NMEAS_W-1:0] r_nmeas     [NUM_CH];
    logic [NMEAS_W-1:0] w_nmeas_nxt [NUM_CH];
    logic [NUM_CH-1:0]  r_sat, w_sat_nxt;
    logic [NUM_CH-1:0]  r_done, w_done_nxt;
    logic [NUM_CH-1:0]  w_fin;
`ifdef PERF_MINMAX_EN
    logic [WIDTH-1:0]   r_min     [NUM_CH];
    logic [WIDTH-1:0]   w_min_nxt [NUM_CH];
    logic [WIDTH-1:0]   r_max     [NUM_CH];
    logic [WIDTH-1:0]   w_max_nxt [NUM_CH];
    logic [WIDTH-1:0]   r_rd_min, w_rd_min;
    logic [WIDTH-1:0]   r_rd_max, w_rd_max;
`endif
    logic [WIDTH-1:0]   r_rd_cnt, w_rd_cnt;
    logic [WIDTH-1:0]   r_rd_last, w_rd_last;
    logic [NMEAS_W-1:0] r_rd_nmeas, w_rd_nmeas;
    logic               r_rd_busy, w_rd_busy;
    logic               r_rd_sat, w_rd_sat;

    // A run completes only when neither a clear nor a restart claims the cycle
    always_comb begin
        w_fin = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            w_fin[i] = (r_state[i] == S_RUN) && bus.cnt_end[i] && !bus.cnt_start[i] && !bus.cnt_clr[i];
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < NUM_CH; i++) r_state[i] <= S_IDLE;
        end else begin
            for (int i = 0; i < NUM_CH; i++) r_state[i] <= w_state_nxt[i];
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            w_state_nxt[i] = r_state[i];
            if (bus.cnt_clr[i])        w_state_nxt[i] = S_IDLE;
            else if (bus.cnt_start[i]) w_state_nxt[i] = S_RUN;
            else if (w_fin[i])         w_state_nxt[i] = S_IDLE;
        end
    end

    // Per-channel datapath next values, priority clr > start > end > count
    always_comb begin
        w_done_nxt = '0;
        w_sat_nxt  = r_sat;
        for (int i = 0; i < NUM_CH; i++) begin
            w_cnt_nxt[i]   = r_cnt[i];
            w_last_nxt[i]  = r_last[i];
            w_nmeas_nxt[i] = r_nmeas[i];
`ifdef PERF_MINMAX_EN
            w_min_nxt[i]   = r_min[i];
            w_max_nxt[i]   = r_max[i];
`endif
            if (bus.cnt_clr[i]) begin
                w_cnt_nxt[i]   = '0;
                w_last_nxt[i]  = '0;
                w_nmeas_nxt[i] = '0;
                w_sat_nxt[i]   = 1'b0;
`ifdef PERF_MINMAX_EN
                w_min_nxt[i]   = CNT_MAX;
                w_max_nxt[i]   = '0;
`endif
            end else if (bus.cnt_start[i]) begin
                w_cnt_nxt[i] = WIDTH'(1);
                w_sat_nxt[i] = 1'b0;
            end else if (w_fin[i]) begin
                w_last_nxt[i] = r_cnt[i];
                w_done_nxt[i] = 1'b1;
                if (r_nmeas[i] != NMEAS_MAX) w_nmeas_nxt[i] = r_nmeas[i] + NMEAS_W'(1);
`ifdef PERF_MINMAX_EN
                if (r_cnt[i] < r_min[i]) w_min_nxt[i] = r_cnt[i];
                if (r_cnt[i] > r_max[i]) w_max_nxt[i] = r_cnt[i];
`endif
            end else if (r_state[i] == S_RUN) begin
                if (r_cnt[i] == CNT_MAX) w_sat_nxt[i] = 1'b1;
                else                     w_cnt_nxt[i] = r_cnt[i] + WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_sat  <= '0;
            r_done <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                r_cnt[i]   <= '0;
                r_last[i]  <= '0;
                r_nmeas[i] <= '0;
`ifdef PERF_MINMAX_EN
                r_min[i]   <= CNT_MAX;
                r_max[i]   <= '0;
`endif
            end
        end else begin
            r_sat  <= w_sat_nxt;
            r_done <= w_done_nxt;
            for (int i = 0; i < NUM_CH; i++) begin
                r_cnt[i]   <= w_cnt_nxt[i];
                r_last[i]  <= w_last_nxt[i];
                r_nmeas[i] <= w_nmeas_nxt[i];
`ifdef PERF_MINMAX_EN
                r_min[i]   <= w_min_nxt[i];
                r_max[i]   <= w_max_nxt[i];
`endif
            end
        end
    end

    // Read mux; an out-of-range select matches no channel and reads zeros
    always_comb begin
        w_rd_cnt   = '0;
        w_rd_last  = '0;
        w_rd_nmeas = '0;
        w_rd_busy  = 1'b0;
        w_rd_sat   = 1'b0;
`ifdef PERF_MINMAX_EN
        w_rd_min   = '0;
        w_rd_max   = '0;
`endif
        for (int i = 0; i < NUM_CH; i++) begin
            if (bus.rd_sel == SEL_W'(i)) begin
                w_rd_cnt   = r_cnt[i];
                w_rd_last  = r_last[i];
                w_rd_nmeas = r_nmeas[i];
                w_rd_busy  = (r_state[i] == S_RUN);
                w_rd_sat   = r_sat[i];
`ifdef PERF_MINMAX_EN
                w_rd_min   = r_min[i];
                w_rd_max   = r_max[i];
`endif
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_rd_cnt   <= '0;
            r_rd_last  <= '0;
            r_rd_nmeas <= '0;
            r_rd_busy  <= 1'b0;
            r_rd_sat   <= 1'b0;
`ifdef PERF_MINMAX_EN
            r_rd_min   <= '0;
            r_rd_max   <= '0;
`endif
        end else begin
            r_rd_cnt   <= w_rd_cnt;
            r_rd_last  <= w_rd_last;
            r_rd_nmeas <= w_rd_nmeas;
            r_rd_busy  <= w_rd_busy;
            r_rd_sat   <= w_rd_sat;
`ifdef PERF_MINMAX_EN
            r_rd_min   <= w_rd_min;
            r_rd_max   <= w_rd_max;
`endif
        end
    end

    assign bus.done     = r_done;
    assign bus.rd_cnt   = r_rd_cnt;
    assign bus.rd_last  = r_rd_last;
    assign bus.rd_nmeas = r_rd_nmeas;
    assign bus.rd_busy  = r_rd_busy;
    assign bus.rd_sat   = r_rd_sat;
`ifdef PERF_MINMAX_EN
    assign bus.rd_min   = r_rd_min;
    assign bus.rd_max   = r_rd_max;
`endif
endmodule

// File: tb/tb_perf_counter_bank.sv
// Bench for perf_counter_bank: a 4-channel 28-bit bank and a 3-channel 4-bit bank share one stimulus
// stream and are compared against a latency model built on start-edge timestamps.
module tb_perf_counter_bank;
    localparam longint MAXA  = 64'h0FFF_FFFF;
    localparam longint MAXB  = 64'd15;
    localparam longint NMMAX = 64'd65535;

    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    perf_counter_bank_if #(.NUM_CH(4), .WIDTH(28), .NMEAS_W(16), .SEL_W(2)) ifa ();
    perf_counter_bank_if #(.NUM_CH(3), .WIDTH(4),  .NMEAS_W(16), .SEL_W(2)) ifb ();

    perf_counter_bank #(.NUM_CH(4), .WIDTH(28), .NMEAS_W(16), .SEL_W(2)) u_a (
        .clk(clk), .resetn(resetn), .bus(ifa));
    perf_counter_bank #(.NUM_CH(3), .WIDTH(4), .NMEAS_W(16), .SEL_W(2)) u_b (
        .clk(clk), .resetn(resetn), .bus(ifb));

    logic [3:0] st, en, cl;
    logic [1:0] sel;

    // Model: a running channel is described by the edge its start was sampled on
    bit     m_run   [2][4];
    longint m_start [2][4];
    longint m_fcnt  [2][4];
    bit     m_fsat  [2][4];
    longint m_last  [2][4];
    longint m_nmeas [2][4];
    longint m_min   [2][4];
    longint m_max   [2][4];
    bit     m_done  [2][4];
    longint x_cnt[2], x_last[2], x_nmeas[2], x_min[2], x_max[2];
    bit     x_busy[2], x_sat[2];
    longint ecnt = 0;
    int     n_chk = 0;
    int     n_fail = 0;

    function automatic longint maxv(int d);
        return (d == 0) ? MAXA : MAXB;
    endfunction

    function automatic int nch(int d);
        return (d == 0) ? 4 : 3;
    endfunction

    function automatic longint mcnt(int d, int c, longint ee);
        longint v;
        if (!m_run[d][c]) return m_fcnt[d][c];
        v = ee - m_start[d][c] + 1;
        return (v > maxv(d)) ? maxv(d) : v;
    endfunction

    function automatic bit msat(int d, int c, longint ee);
        if (!m_run[d][c]) return m_fsat[d][c];
        return (ee - m_start[d][c] + 1) > maxv(d);
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            for (int c = 0; c < 4; c++) begin
                m_run[d][c] = 0; m_start[d][c] = 0; m_fcnt[d][c] = 0; m_fsat[d][c] = 0;
                m_last[d][c] = 0; m_nmeas[d][c] = 0; m_min[d][c] = maxv(d); m_max[d][c] = 0;
                m_done[d][c] = 0;
            end
        end
    endtask

    task automatic drive();
        ifa.cnt_start = st;      ifa.cnt_end = en;      ifa.cnt_clr = cl;      ifa.rd_sel = sel;
        ifb.cnt_start = st[2:0]; ifb.cnt_end = en[2:0]; ifb.cnt_clr = cl[2:0]; ifb.rd_sel = sel;
    endtask

    // One clock edge: apply inputs, advance the model, sample 1 time unit after the edge
    task automatic step();
        longint lat;
        bit     lsat;
        drive();
        @(posedge clk);
        for (int d = 0; d < 2; d++) begin
            if (int'(sel) < nch(d)) begin
                x_cnt[d]   = mcnt(d, int'(sel), ecnt - 1);
                x_sat[d]   = msat(d, int'(sel), ecnt - 1);
                x_last[d]  = m_last[d][sel];
                x_nmeas[d] = m_nmeas[d][sel];
                x_busy[d]  = m_run[d][sel];
                x_min[d]   = m_min[d][sel];
                x_max[d]   = m_max[d][sel];
            end else begin
                x_cnt[d] = 0; x_sat[d] = 0; x_last[d] = 0; x_nmeas[d] = 0;
                x_busy[d] = 0; x_min[d] = 0; x_max[d] = 0;
            end
            for (int c = 0; c < nch(d); c++) begin
                m_done[d][c] = 0;
                if (cl[c]) begin
                    m_run[d][c] = 0; m_fcnt[d][c] = 0; m_fsat[d][c] = 0; m_last[d][c] = 0;
                    m_nmeas[d][c] = 0; m_min[d][c] = maxv(d); m_max[d][c] = 0;
                end else if (st[c]) begin
                    m_run[d][c] = 1; m_start[d][c] = ecnt;
                end else if (en[c] && m_run[d][c]) begin
                    lat  = mcnt(d, c, ecnt - 1);
                    lsat = msat(d, c, ecnt - 1);
                    m_run[d][c] = 0; m_fcnt[d][c] = lat; m_fsat[d][c] = lsat; m_last[d][c] = lat;
                    m_nmeas[d][c] = (m_nmeas[d][c] < NMMAX) ? m_nmeas[d][c] + 1 : NMMAX;
                    m_done[d][c] = 1;
                    if (lat < m_min[d][c]) m_min[d][c] = lat;
                    if (lat > m_max[d][c]) m_max[d][c] = lat;
                end
            end
        end
        ecnt++;
        #1;
        st = '0; en = '0; cl = '0;
    endtask

    task automatic test_reset();
        st = '0; en = '0; cl = '0; sel = '0;
        drive();
        resetn = 1'b0;
        model_reset();
        #23;
        n_chk++;
        if ({ifa.done, ifa.rd_busy, ifa.rd_sat, ifa.rd_nmeas, ifa.rd_last, ifa.rd_cnt} !== 78'd0) begin
            n_fail++;
            $display("FAIL reset_a: got done=%h busy=%b sat=%b nmeas=%0d last=%0d cnt=%0d, want all 0",
                     ifa.done, ifa.rd_busy, ifa.rd_sat, ifa.rd_nmeas, ifa.rd_last, ifa.rd_cnt);
        end
        n_chk++;
        if ({ifb.done, ifb.rd_busy, ifb.rd_sat, ifb.rd_nmeas, ifb.rd_last, ifb.rd_cnt} !== 29'd0) begin
            n_fail++;
            $display("FAIL reset_b: got %h, want 0",
                     {ifb.done, ifb.rd_busy, ifb.rd_sat, ifb.rd_nmeas, ifb.rd_last, ifb.rd_cnt});
        end
        @(negedge clk);
        resetn = 1'b1;
    endtask

    task automatic test_basic();
        bit early;
        early = 0;
        sel = 2'd0;
        st[0] = 1'b1; step();
        for (int k = 1; k < 10; k++) begin
            sel = 2'd0; step();
            if (ifa.done[0] !== 1'b0) early = 1;
        end
        n_chk++;
        if (early) begin n_fail++; $display("FAIL basic_no_early_done: got done before end, want none"); end
        sel = 2'd0; en[0] = 1'b1; step();
        n_chk++;
        if (ifa.done !== 4'b0001 || ifb.done !== 3'b001) begin
            n_fail++; $display("FAIL basic_done: got a=%b b=%b, want 0001/001", ifa.done, ifb.done);
        end
        sel = 2'd0; step();
        n_chk++;
        if (ifa.done[0] !== 1'b0) begin n_fail++; $display("FAIL basic_done_one_cycle: got %b, want 0", ifa.done[0]); end
        n_chk++;
        if (ifa.rd_last !== 28'd10 || ifb.rd_last !== 4'd10) begin
            n_fail++; $display("FAIL basic_last: got a=%0d b=%0d, want 10", ifa.rd_last, ifb.rd_last);
        end
        n_chk++;
        if (ifa.rd_nmeas !== 16'd1 || ifa.rd_busy !== 1'b0) begin
            n_fail++; $display("FAIL basic_nmeas_busy: got nmeas=%0d busy=%b, want 1/0", ifa.rd_nmeas, ifa.rd_busy);
        end
    endtask

    task automatic test_restart();
        sel = 2'd1;
        st[1] = 1'b1; step();
        repeat (4) begin sel = 2'd1; step(); end
        sel = 2'd1; st[1] = 1'b1; step();
        repeat (2) begin sel = 2'd1; step(); end
        sel = 2'd1; en[1] = 1'b1; step();
        sel = 2'd1; step();
        n_chk++;
        if (ifa.rd_last !== 28'd3 || ifa.rd_nmeas !== 16'd1) begin
            n_fail++; $display("FAIL restart_last: got last=%0d nmeas=%0d, want 3/1", ifa.rd_last, ifa.rd_nmeas);
        end
        sel = 2'd1; st[1] = 1'b1; en[1] = 1'b1; step();
        n_chk++;
        if (ifa.done[1] !== 1'b0) begin n_fail++; $display("FAIL start_end_done: got %b, want 0", ifa.done[1]); end
        sel = 2'd1; step();
        n_chk++;
        if (ifa.rd_busy !== 1'b1 || ifa.rd_cnt !== 28'd1 || ifa.rd_nmeas !== 16'd1) begin
            n_fail++; $display("FAIL start_end_run: got busy=%b cnt=%0d nmeas=%0d, want 1/1/1",
                               ifa.rd_busy, ifa.rd_cnt, ifa.rd_nmeas);
        end
        sel = 2'd1; en[1] = 1'b1; step();
    endtask

    task automatic test_saturation();
        sel = 2'd0;
        st[0] = 1'b1; step();
        repeat (20) begin sel = 2'd0; step(); end
        sel = 2'd0; en[0] = 1'b1; step();
        sel = 2'd0; step();
        n_chk++;
        if (ifb.rd_cnt !== 4'd15 || ifb.rd_sat !== 1'b1 || ifb.rd_last !== 4'd15) begin
            n_fail++; $display("FAIL sat_b: got cnt=%0d sat=%b last=%0d, want 15/1/15", ifb.rd_cnt, ifb.rd_sat, ifb.rd_last);
        end
        n_chk++;
        if (ifa.rd_last !== 28'd21 || ifa.rd_sat !== 1'b0) begin
            n_fail++; $display("FAIL sat_a_wide: got last=%0d sat=%b, want 21/0", ifa.rd_last, ifa.rd_sat);
        end
        sel = 2'd0; st[0] = 1'b1; step();
        sel = 2'd0; step();
        n_chk++;
        if (ifb.rd_sat !== 1'b0 || ifb.rd_cnt !== 4'd1) begin
            n_fail++; $display("FAIL sat_restart: got sat=%b cnt=%0d, want 0/1", ifb.rd_sat, ifb.rd_cnt);
        end
        sel = 2'd0; en[0] = 1'b1; step();
    endtask

    task automatic test_clear();
        sel = 2'd2;
        repeat (3) begin
            st[2] = 1'b1; step();
            step();
            en[2] = 1'b1; step();
        end
        step();
        n_chk++;
        if (ifa.rd_nmeas !== 16'd3 || ifa.rd_last !== 28'd2) begin
            n_fail++; $display("FAIL clr_pre: got nmeas=%0d last=%0d, want 3/2", ifa.rd_nmeas, ifa.rd_last);
        end
        st[2] = 1'b1; step();
        step();
        cl[2] = 1'b1; st[2] = 1'b1; en[2] = 1'b1; step();
        n_chk++;
        if (ifa.done[2] !== 1'b0 || ifb.done[2] !== 1'b0) begin
            n_fail++; $display("FAIL clr_no_done: got a=%b b=%b, want 0", ifa.done[2], ifb.done[2]);
        end
        step();
        n_chk++;
        if ({ifa.rd_busy, ifa.rd_sat, ifa.rd_nmeas, ifa.rd_last, ifa.rd_cnt} !== 74'd0) begin
            n_fail++; $display("FAIL clr_state: got busy=%b nmeas=%0d last=%0d cnt=%0d, want 0",
                               ifa.rd_busy, ifa.rd_nmeas, ifa.rd_last, ifa.rd_cnt);
        end
        en[2] = 1'b1; step();
        n_chk++;
        if (ifa.done[2] !== 1'b0) begin n_fail++; $display("FAIL idle_end_done: got %b, want 0", ifa.done[2]); end
        step();
        n_chk++;
        if (ifa.rd_busy !== 1'b0 || ifa.rd_cnt !== 28'd0 || ifa.rd_nmeas !== 16'd0) begin
            n_fail++; $display("FAIL idle_end_state: got busy=%b cnt=%0d nmeas=%0d, want 0", ifa.rd_busy, ifa.rd_cnt, ifa.rd_nmeas);
        end
    endtask

    task automatic test_independence();
        longint exp_l[4];
        for (int k = 0; k < 15; k++) begin
            sel = 2'd2;
            if (k == 0)  st[0] = 1'b1;
            if (k == 2)  st[3] = 1'b1;
            if (k == 7)  en[0] = 1'b1;
            if (k == 14) en[3] = 1'b1;
            step();
        end
        exp_l[0] = 7; exp_l[1] = m_last[0][1]; exp_l[2] = m_last[0][2]; exp_l[3] = 12;
        for (int s = 0; s < 4; s++) begin
            sel = 2'(s); step();
            n_chk++;
            if (ifa.rd_last !== 28'(exp_l[s])) begin
                n_fail++; $display("FAIL sweep_a sel=%0d: got last=%0d, want %0d", s, ifa.rd_last, exp_l[s]);
            end
            n_chk++;
            if (ifb.rd_last !== ((s < 3) ? 4'(exp_l[s]) : 4'd0) || (s == 3 && ifb.rd_nmeas !== 16'd0)) begin
                n_fail++; $display("FAIL sweep_b sel=%0d: got last=%0d nmeas=%0d", s, ifb.rd_last, ifb.rd_nmeas);
            end
            ifa.rd_sel = 2'(s + 1);
            #1;
            n_chk++;
            if (ifa.rd_last !== 28'(exp_l[s])) begin
                n_fail++; $display("FAIL read_latency sel=%0d: got last=%0d, want %0d before edge", s, ifa.rd_last, exp_l[s]);
            end
        end
    endtask

`ifdef PERF_MINMAX_EN
    task automatic test_minmax();
        int lats[3];
        lats[0] = 9; lats[1] = 4; lats[2] = 15;
        sel = 2'd0; cl[0] = 1'b1; step();
        for (int j = 0; j < 3; j++) begin
            st[0] = 1'b1; step();
            repeat (lats[j] - 1) step();
            en[0] = 1'b1; step();
        end
        step();
        n_chk++;
        if (ifa.rd_min !== 28'd4 || ifa.rd_max !== 28'd15 || ifb.rd_min !== 4'd4 || ifb.rd_max !== 4'd15) begin
            n_fail++; $display("FAIL minmax: got a=%0d/%0d b=%0d/%0d, want 4/15", ifa.rd_min, ifa.rd_max, ifb.rd_min, ifb.rd_max);
        end
        cl[0] = 1'b1; step();
        step();
        n_chk++;
        if (ifa.rd_min !== 28'hFFF_FFFF || ifa.rd_max !== 28'd0 || ifb.rd_min !== 4'hF || ifb.rd_max !== 4'd0) begin
            n_fail++; $display("FAIL minmax_clr: got a=%h/%h b=%h/%h, want ones/0", ifa.rd_min, ifa.rd_max, ifb.rd_min, ifb.rd_max);
        end
    endtask
`endif

    task automatic test_random();
        logic [77:0] exp_a;
        logic [28:0] exp_b;
        logic [3:0]  xd_a;
        logic [2:0]  xd_b;
        for (int n = 0; n < 600; n++) begin
            for (int c = 0; c < 4; c++) begin
                st[c] = ($urandom_range(15) == 0);
                en[c] = ($urandom_range(7) == 0);
                cl[c] = ($urandom_range(63) == 0);
            end
            sel = 2'($urandom_range(3));
            step();
            for (int c = 0; c < 4; c++) xd_a[c] = m_done[0][c];
            for (int c = 0; c < 3; c++) xd_b[c] = m_done[1][c];
            exp_a = {xd_a, x_busy[0], x_sat[0], 16'(x_nmeas[0]), 28'(x_last[0]), 28'(x_cnt[0])};
            exp_b = {xd_b, x_busy[1], x_sat[1], 16'(x_nmeas[1]), 4'(x_last[1]), 4'(x_cnt[1])};
            n_chk++;
            if ({ifa.done, ifa.rd_busy, ifa.rd_sat, ifa.rd_nmeas, ifa.rd_last, ifa.rd_cnt} !== exp_a) begin
                n_fail++; $display("FAIL rand_a n=%0d sel=%0d: got %h, want %h", n, sel,
                    {ifa.done, ifa.rd_busy, ifa.rd_sat, ifa.rd_nmeas, ifa.rd_last, ifa.rd_cnt}, exp_a);
            end
            n_chk++;
            if ({ifb.done, ifb.rd_busy, ifb.rd_sat, ifb.rd_nmeas, ifb.rd_last, ifb.rd_cnt} !== exp_b) begin
                n_fail++; $display("FAIL rand_b n=%0d sel=%0d: got %h, want %h", n, sel,
                    {ifb.done, ifb.rd_busy, ifb.rd_sat, ifb.rd_nmeas, ifb.rd_last, ifb.rd_cnt}, exp_b);
            end
`ifdef PERF_MINMAX_EN
            n_chk++;
            if (ifa.rd_min !== 28'(x_min[0]) || ifa.rd_max !== 28'(x_max[0]) ||
                ifb.rd_min !== 4'(x_min[1]) || ifb.rd_max !== 4'(x_max[1])) begin
                n_fail++; $display("FAIL rand_minmax n=%0d: got a=%0d/%0d b=%0d/%0d, want %0d/%0d %0d/%0d", n,
                    ifa.rd_min, ifa.rd_max, ifb.rd_min, ifb.rd_max, x_min[0], x_max[0], x_min[1], x_max[1]);
            end
`endif
        end
    endtask

    task automatic test_async_reset();
        sel = 2'd0; cl = 4'hF; step();
        sel = 2'd0; st[0] = 1'b1; step();
        sel = 2'd0; step();
        sel = 2'd0; step();
        n_chk++;
        if (ifa.rd_busy !== 1'b1) begin n_fail++; $display("FAIL async_pre_busy: got %b, want 1", ifa.rd_busy); end
        #2;
        resetn = 1'b0;
        #1;
        n_chk++;
        if (ifa.rd_busy !== 1'b0 || ifa.rd_cnt !== 28'd0 || ifb.rd_busy !== 1'b0) begin
            n_fail++; $display("FAIL async_reset: got busy=%b cnt=%0d, want 0/0", ifa.rd_busy, ifa.rd_cnt);
        end
        model_reset();
        @(negedge clk);
        resetn = 1'b1;
        sel = 2'd0; step();
        sel = 2'd0; step();
        n_chk++;
        if (ifa.rd_busy !== 1'b0 || ifa.rd_cnt !== 28'd0 || ifa.rd_nmeas !== 16'd0) begin
            n_fail++; $display("FAIL post_reset: got busy=%b cnt=%0d nmeas=%0d, want 0", ifa.rd_busy, ifa.rd_cnt, ifa.rd_nmeas);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_restart();
        test_saturation();
        test_clear();
        test_independence();
`ifdef PERF_MINMAX_EN
        test_minmax();
`endif
        test_random();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
